// File: rtl/z_csa_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Stage 1 precomputes each block's sum/carry for carry-in 0 and 1; stage 2 runs
// the select chain that resolves block carries and registers the result.
module z_csa_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLOCK;

    // Refuse to elaborate with a block size that does not tile the word.
    generate
        if (BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_bad_params
            $error("z_csa_pipe_adder: WIDTH must be a multiple of BLOCK and 1 <= BLOCK <= WIDTH");
        end
    endgenerate

    // Effective operands: subtraction is a + ~b + 1, so c_in is ignored then.
    logic [WIDTH-1:0] bx;
    logic             cx;

    assign bx = sub ? ~b : b;
    assign cx = sub ? 1'b1 : c_in;

    // Per-block speculative results for carry-in 0 and carry-in 1.
    logic [NBLK-1:0][BLOCK-1:0] s0_next, s1_next;
    logic [NBLK-1:0]            co0_next, co1_next;

    generate
        for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
            assign {co0_next[gi], s0_next[gi]} =
                {1'b0, a[gi*BLOCK +: BLOCK]} + {1'b0, bx[gi*BLOCK +: BLOCK]};
            assign {co1_next[gi], s1_next[gi]} =
                {1'b0, a[gi*BLOCK +: BLOCK]} + {1'b0, bx[gi*BLOCK +: BLOCK]} + (BLOCK+1)'(1);
        end
    endgenerate

    // Stage-1 registers.
    logic [NBLK-1:0][BLOCK-1:0] s0_reg, s1_reg;
    logic [NBLK-1:0]            co0_reg, co1_reg;
    logic                       cx_reg;
    logic                       a_msb_reg;
    logic                       bx_msb_reg;
    logic                       s1_valid_reg;

    // Stage-2 (output) registers.
    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;
    logic             ovf_reg;
    logic             out_valid_reg;

    // Handshake: a stage may advance when its successor is empty or draining.
    logic adv1, adv2;

    assign adv2     = !out_valid_reg || out_ready;
    assign adv1     = !s1_valid_reg || adv2;
    assign in_ready = adv1;

    // Carry-select chain: each block's carry-in picks one of its two precomputed results.
    logic [NBLK:0]    carry;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;

    always_comb begin
        carry    = '0;
        sum_next = '0;
        carry[0] = cx_reg;
        for (int k = 0; k < NBLK; k++) begin
            sum_next[k*BLOCK +: BLOCK] = carry[k] ? s1_reg[k] : s0_reg[k];
            carry[k+1]                 = carry[k] ? co1_reg[k] : co0_reg[k];
        end
        ovf_next = (a_msb_reg == bx_msb_reg) && (sum_next[WIDTH-1] != a_msb_reg);
    end

    // Stage 1: capture a new beat whenever the stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_reg       <= '0;
            s1_reg       <= '0;
            co0_reg      <= '0;
            co1_reg      <= '0;
            cx_reg       <= 1'b0;
            a_msb_reg    <= 1'b0;
            bx_msb_reg   <= 1'b0;
            s1_valid_reg <= 1'b0;
        end else if (adv1) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s0_reg     <= s0_next;
                s1_reg     <= s1_next;
                co0_reg    <= co0_next;
                co1_reg    <= co1_next;
                cx_reg     <= cx;
                a_msb_reg  <= a[WIDTH-1];
                bx_msb_reg <= bx[WIDTH-1];
            end
        end
    end

    // Stage 2: register the resolved result; hold it while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg       <= '0;
            c_out_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (adv2) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                sum_reg   <= sum_next;
                c_out_reg <= carry[NBLK];
                ovf_reg   <= ovf_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign c_out     = c_out_reg;
    assign ovf       = ovf_reg;

endmodule
